// File: rtl/xtea_enc_arbiter.sv
// Round-robin arbiter that shares one 128-bit XTEA-style encoder core
// between N_REQ requesters. It captures the winner's operands, sequences
// the core's enable/done protocol and returns the result through a
// per-requester valid/ready handshake. A watchdog aborts a hung core.
module xtea_enc_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*128-1:0] req_data,
    input  logic [N_REQ*128-1:0] req_key,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   resp_valid,
    input  logic [N_REQ-1:0]   resp_ready,
    output logic [127:0]       resp_data,
    output logic               resp_err,
    output logic               busy,
    output logic               enc_enable,
    output logic [127:0]       enc_data_in,
    output logic [127:0]       enc_key_in,
    input  logic [127:0]       enc_data_out,
    input  logic               enc_done
);
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DELIVER} state_t;

    // Operands captured at grant time; the requester may change its inputs afterwards.
    typedef struct packed {
        logic [127:0] data;
        logic [127:0] key;
    } job_t;

    state_t        state, state_n;
    job_t          job;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] owner;
    logic [7:0]    wd;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          wd_expired;

    assign enc_data_in = job.data;
    assign enc_key_in  = job.key;
    assign busy        = (state != IDLE);
    assign wd_expired  = (wd == 8'(TIMEOUT - 1));

    // Round-robin search: first set request starting just after the last owner.
    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(rr_ptr) + k) % N_REQ;
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IW-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next state plus core enable and response decode. In RUN the enable drops
    // combinationally with done so the core cannot see enable after finishing.
    always_comb begin
        state_n    = state;
        enc_enable = 1'b0;
        resp_valid = '0;
        case (state)
            IDLE:    if (pick_found) state_n = LOAD;
            LOAD: begin
                enc_enable = 1'b1;
                state_n    = RUN;
            end
            RUN: begin
                enc_enable = ~enc_done;
                if (enc_done || wd_expired) state_n = DELIVER;
            end
            DELIVER: begin
                resp_valid[owner] = 1'b1;
                if (resp_ready[owner]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Grant pulse, operand capture, result capture and watchdog.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gnt       <= '0;
            rr_ptr    <= IW'(N_REQ - 1);
            owner     <= '0;
            job       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            wd        <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt[pick_idx] <= 1'b1;
                        owner         <= pick_idx;
                        rr_ptr        <= pick_idx;
                        job.data      <= req_data[int'(pick_idx)*128 +: 128];
                        job.key       <= req_key[int'(pick_idx)*128 +: 128];
                    end
                end
                RUN: begin
                    if (enc_done) begin
                        resp_data <= enc_data_out;
                        resp_err  <= 1'b0;
                    end else if (wd_expired) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                DELIVER: begin
                    if (resp_ready[owner]) wd <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_xtea_enc_arbiter.sv
// Directed bench for xtea_enc_arbiter with a behavioural stub encoder core.
module tb_xtea_enc_arbiter;
    localparam int N   = 4;
    localparam int LAT = 6;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0]       req = '0;
    logic [N*128-1:0]   req_data = '0;
    logic [N*128-1:0]   req_key = '0;
    logic [N-1:0]       gnt;
    logic [N-1:0]       resp_valid;
    logic [N-1:0]       resp_ready = '0;
    logic [127:0]       resp_data;
    logic               resp_err;
    logic               busy;
    logic               enc_enable;
    logic [127:0]       enc_data_in;
    logic [127:0]       enc_key_in;
    logic [127:0]       enc_data_out;
    logic               enc_done;

    int n_cmp = 0;
    int n_err = 0;
    int viol  = 0;
    bit core_stuck = 1'b0;

    always #5 clock = ~clock;

    xtea_enc_arbiter #(.N_REQ(N), .TIMEOUT(10)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .req_key(req_key), .gnt(gnt), .resp_valid(resp_valid),
        .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy), .enc_enable(enc_enable), .enc_data_in(enc_data_in),
        .enc_key_in(enc_key_in), .enc_data_out(enc_data_out), .enc_done(enc_done)
    );

    // Stub core transform.
    function automatic logic [127:0] core_f(input logic [127:0] d, input logic [127:0] k);
        return {d[63:0] ^ k[127:64], d[127:64] + k[63:0]} ^ {4{32'h9E3779B9}};
    endfunction

    // Stub core: loads on a rising enable, done after LAT cycles, done holds until reload.
    logic         en_q;
    logic [7:0]   cnt;
    logic [127:0] cd, ck;
    int           loads;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en_q <= 1'b0; cnt <= '0; enc_done <= 1'b0; enc_data_out <= '0;
            cd <= '0; ck <= '0; loads <= 0;
        end else begin
            en_q <= enc_enable;
            if (enc_enable && !en_q) begin
                cd <= enc_data_in; ck <= enc_key_in; cnt <= 8'(LAT);
                enc_done <= 1'b0; loads <= loads + 1;
            end else if (cnt != 0 && !core_stuck) begin
                cnt <= cnt - 8'd1;
                if (cnt == 8'd1) begin
                    enc_done     <= 1'b1;
                    enc_data_out <= core_f(cd, ck);
                end
            end
        end
    end

    // Enable held high (beyond the load cycle) while the core reports done.
    always @(negedge clock)
        if (!reset && enc_enable && enc_done && en_q) viol <= viol + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(output int g, output int t);
        g = -1; t = -1;
        for (int i = 0; i < 60 && g < 0; i++) begin
            @(negedge clock);
            t = i;
            for (int j = 0; j < N; j++) if (gnt[j]) g = j;
        end
    endtask

    task automatic do_job(input int idx, input logic [127:0] d, input logic [127:0] k,
                          input int exp_g, input int rdly, input bit exp_err,
                          input logic [N-1:0] side_req, input logic [N-1:0] side_ready,
                          output int lat);
        int g, t, bad, ld0;
        logic [127:0] exp_d;
        exp_d = exp_err ? 128'd0 : core_f(d, k);
        req_data[128*idx +: 128] = d;
        req_key[128*idx +: 128]  = k;
        req[idx] = 1'b1;
        wait_gnt(g, t);
        check("gnt_idx", 128'(g), 128'(exp_g));
        check("gnt_latency", 128'(t), 128'd0);
        check("gnt_onehot", 128'($countones(gnt)), 128'd1);
        if (g >= 0) req[g] = 1'b0;
        // Operands must already be captured: scramble the inputs.
        req_data[128*idx +: 128] = ~d;
        req_key[128*idx +: 128]  = ~k;
        req = req | side_req;
        resp_ready = resp_ready | side_ready;
        lat = 0; bad = 0;
        for (int i = 0; i < 60 && resp_valid == '0; i++) begin
            @(negedge clock);
            lat++;
            if (gnt != '0) bad++;
        end
        check("resp_valid", 128'(resp_valid), 128'(1 << exp_g));
        check("resp_data", resp_data, exp_d);
        check("resp_err", 128'(resp_err), 128'(exp_err));
        ld0 = loads;
        repeat (rdly) begin
            @(negedge clock);
            if (resp_valid != N'(1 << exp_g) || resp_data !== exp_d || gnt != '0 || enc_enable)
                bad++;
        end
        check("hold_stable", 128'(bad), 128'd0);
        check("no_reload", 128'(loads), 128'(ld0));
        resp_ready[exp_g] = 1'b1;
        @(negedge clock);
        check("busy_after_ready", 128'(busy), 128'd0);
        check("valid_after_ready", 128'(resp_valid), 128'd0);
        resp_ready = '0;
    endtask

    typedef struct {
        int           idx;
        logic [127:0] data;
        logic [127:0] key;
        int           exp_g;
        int           rdly;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int order[5];
        int g, t, lat;

        vecs[0] = '{0, 128'h0123456789ABCDEF0123456789ABCDEF, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 0, 0};
        vecs[1] = '{2, 128'h00112233445566778899AABBCCDDEEFF, 128'h000102030405060708090A0B0C0D0E0F, 2, 3};
        vecs[2] = '{1, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 128'h00000000000000000000000000000001, 1, 0};
        vecs[3] = '{3, 128'h0, 128'hDEADBEEFCAFEF00D0BADC0DE12345678, 3, 1};

        // Reset values.
        repeat (2) @(negedge clock);
        check("rst_gnt", 128'(gnt), 128'd0);
        check("rst_resp_valid", 128'(resp_valid), 128'd0);
        check("rst_resp_data", resp_data, 128'd0);
        check("rst_resp_err", 128'(resp_err), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_enc_enable", 128'(enc_enable), 128'd0);
        check("rst_enc_data_in", enc_data_in, 128'd0);
        check("rst_enc_key_in", enc_key_in, 128'd0);
        reset = 1'b0;
        @(negedge clock);

        // Single-requester jobs from the table.
        for (int v = 0; v < 4; v++)
            do_job(vecs[v].idx, vecs[v].data, vecs[v].key, vecs[v].exp_g, vecs[v].rdly,
                   1'b0, '0, '0, lat);

        // All requesting, ready tied high: order continues after last owner 3.
        req = '1; resp_ready = '1;
        for (int i = 0; i < 5; i++) begin
            wait_gnt(g, t);
            order[i] = g;
        end
        req = '0;
        for (int i = 0; i < 60 && busy; i++) @(negedge clock);
        resp_ready = '0;
        check("rr_busy_idle", 128'(busy), 128'd0);
        for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), 128'(order[i]), 128'(i % 4));

        // Owner 2, then 0 and 2 together: search from 3 wraps to 0, then 2.
        do_job(2, 128'h1111, 128'h2222, 2, 0, 1'b0, '0, '0, lat);
        req_data[256 +: 128] = 128'h5555; req_key[256 +: 128] = 128'h6666; req[2] = 1'b1;
        do_job(0, 128'h3333, 128'h4444, 0, 0, 1'b0, '0, '0, lat);
        do_job(2, 128'h5555, 128'h6666, 2, 0, 1'b0, '0, '0, lat);

        // Owner 1 held in DELIVER 20 cycles; req[0] pending and its ready high.
        do_job(1, 128'hA5A5_0000_FFFF_1234, 128'h77, 1, 20, 1'b0, 4'b0001, 4'b0001, lat);
        do_job(0, 128'hBEEF, 128'hF00D, 0, 0, 1'b0, '0, '0, lat);

        // Hung core: abort after 10 RUN cycles, then a normal job.
        core_stuck = 1'b1;
        do_job(3, 128'h9999, 128'h8888, 3, 0, 1'b1, '0, '0, lat);
        check("timeout_latency", 128'(lat), 128'd11);
        core_stuck = 1'b0;
        do_job(1, 128'hC0FFEE, 128'h1234_5678, 1, 0, 1'b0, '0, '0, lat);

        // Reset in the middle of RUN.
        req_data[256 +: 128] = 128'h4242; req_key[256 +: 128] = 128'h2424; req[2] = 1'b1;
        wait_gnt(g, t);
        check("mid_gnt", 128'(g), 128'd2);
        req[2] = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_running", 128'(enc_enable), 128'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_enable", 128'(enc_enable), 128'd0);
        check("mid_rst_valid", 128'(resp_valid), 128'd0);
        check("mid_rst_data_in", enc_data_in, 128'd0);
        check("mid_rst_key_in", enc_key_in, 128'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_job(3, 128'h0123456789ABCDEF0123456789ABCDEF, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0,
               3, 0, 1'b0, '0, '0, lat);

        check("enable_while_done", 128'(viol), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
